// File: rtl/ysyx_icache_pkg.sv
// Shared types and constants for the instruction cache slice.
package ysyx_icache_pkg;

  // Cache controller states: lookup/serve, or fetching a full line from the bus.
  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  localparam int OFFSET_BITS = 2;
  localparam int LINE_WORDS  = 4;

endpackage

// File: rtl/ysyx_icache_if.sv
// Fetch-port and arbiter-read signals of the instruction cache, bundled.
interface ysyx_icache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Handshakes: the IFU holds ifu_req and ifu_pc stable until it sees the
  // one-cycle ifu_rvalid pulse. On the bus side the cache holds bus_arvalid
  // and bus_araddr stable until the arbiter answers with a one-cycle
  // bus_rvalid carrying bus_rdata; each bus_rvalid completes exactly one word.
  logic [ADDR_W-1:0] ifu_pc;
  logic              ifu_req;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_rvalid;
  logic [ADDR_W-1:0] bus_araddr;
  logic              bus_arvalid;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rvalid;

  // Cache side.
  modport slave (
    input  ifu_pc, ifu_req, bus_rdata, bus_rvalid,
    output ifu_rdata, ifu_rvalid, bus_araddr, bus_arvalid
  );

  // IFU plus arbiter side.
  modport master (
    output ifu_pc, ifu_req, bus_rdata, bus_rvalid,
    input  ifu_rdata, ifu_rvalid, bus_araddr, bus_arvalid
  );

endinterface

// File: rtl/ysyx_icache_array.sv
// Register-based valid/tag/data storage: one word-granular write port,
// combinational read, and a flash clear of all valid bits.
module ysyx_icache_array
  import ysyx_icache_pkg::*;
#(
  parameter int SET_BITS = 4,
  parameter int TAG_W    = 24,
  parameter int DATA_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic [SET_BITS-1:0]    rd_idx_i,
  input  logic [OFFSET_BITS-1:0] rd_off_i,
  output logic                   rd_valid_o,
  output logic [TAG_W-1:0]       rd_tag_o,
  output logic [DATA_W-1:0]      rd_data_o,
  input  logic                   wr_en_i,
  input  logic                   wr_last_i,
  input  logic                   wr_valid_i,
  input  logic [SET_BITS-1:0]    wr_idx_i,
  input  logic [OFFSET_BITS-1:0] wr_off_i,
  input  logic [TAG_W-1:0]       wr_tag_i,
  input  logic [DATA_W-1:0]      wr_data_i
);

  localparam int SETS = 1 << SET_BITS;

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS][LINE_WORDS];

  // Valid bits: reset and flash clear win over the last-beat line install.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      valid_q <= '0;
    end else if (wr_en_i && wr_last_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
    end
  end

  // Tag and data are not reset; they are only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_data_i;
      if (wr_last_i) begin
        tag_q[wr_idx_i] <= wr_tag_i;
      end
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/ysyx_icache.sv
// Direct-mapped instruction cache, 4-word lines refilled in order through
// single-word arbiter reads. fence_i invalidates every line.
// Optional build macro: YSYX_ICACHE_PERF_EN enables hit/miss counters.
module ysyx_icache
  import ysyx_icache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SET_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fence_i,
  ysyx_icache_if.slave        port_if,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o,
  output state_e              dbg_state_o
);

  localparam int LINE_W = ADDR_W - 4;
  localparam int TAG_W  = ADDR_W - 4 - SET_BITS;

  state_e                 state_q, state_d;
  logic [1:0]             beat_q, beat_d;
  logic [LINE_W-1:0]      base_q, base_d;
  logic [OFFSET_BITS-1:0] off_q, off_d;
  logic                   fence_seen_q, fence_seen_d;
  logic                   rvalid_q, rvalid_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  logic [SET_BITS-1:0]    pc_idx, base_idx, rd_idx;
  logic [TAG_W-1:0]       pc_tag, base_tag, rd_tag;
  logic [OFFSET_BITS-1:0] pc_off, rd_off;
  logic                   rd_valid, wr_valid;
  logic [DATA_W-1:0]      rd_data;
  logic                   req_accept, lookup_hit, idle_hit, idle_miss;
  logic                   refill_beat, refill_last;
  logic                   unused_pc_bits;

  assign pc_idx         = port_if.ifu_pc[3+SET_BITS:4];
  assign pc_tag         = port_if.ifu_pc[ADDR_W-1:4+SET_BITS];
  assign pc_off         = port_if.ifu_pc[3:2];
  assign base_idx       = base_q[SET_BITS-1:0];
  assign base_tag       = base_q[LINE_W-1:SET_BITS];
  assign unused_pc_bits = ^port_if.ifu_pc[1:0];

  // A request is looked at only in IDLE and never in the cycle its answer is out.
  assign req_accept  = (state_q == IDLE) && port_if.ifu_req && !rvalid_q;
  assign lookup_hit  = rd_valid && (rd_tag == pc_tag);
  assign idle_hit    = req_accept && lookup_hit;
  assign idle_miss   = req_accept && !lookup_hit;
  assign refill_beat = (state_q == REFILL) && port_if.bus_rvalid;
  assign refill_last = refill_beat && (beat_q == 2'd3);

  ysyx_icache_array #(
    .SET_BITS (SET_BITS),
    .TAG_W    (TAG_W),
    .DATA_W   (DATA_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (fence_i),
    .rd_idx_i   (rd_idx),
    .rd_off_i   (rd_off),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (refill_beat),
    .wr_last_i  (refill_last),
    .wr_valid_i (wr_valid),
    .wr_idx_i   (base_idx),
    .wr_off_i   (beat_q),
    .wr_tag_i   (base_tag),
    .wr_data_i  (port_if.bus_rdata)
  );

  // State register plus refill bookkeeping and the registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      base_q       <= '0;
      off_q        <= '0;
      fence_seen_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      off_q        <= off_d;
      fence_seen_q <= fence_seen_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next state: a miss starts a refill, the fourth beat ends it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (idle_miss)   state_d = REFILL;
      REFILL:  if (refill_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Refill bookkeeping; a fence seen mid-refill keeps the new line invalid.
  always_comb begin
    beat_d       = beat_q;
    base_d       = base_q;
    off_d        = off_q;
    fence_seen_d = fence_seen_q;
    if (idle_miss) begin
      base_d       = port_if.ifu_pc[ADDR_W-1:4];
      off_d        = pc_off;
      beat_d       = '0;
      fence_seen_d = 1'b0;
    end else if (state_q == REFILL) begin
      if (fence_i)     fence_seen_d = 1'b1;
      if (refill_beat) beat_d       = beat_q + 2'd1;
      if (refill_last) fence_seen_d = 1'b0;
    end
  end

  // Response: hit word from the array, or on the last beat the requested word
  // (bypassing the array when it is the word arriving right now).
  always_comb begin
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    if (idle_hit) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data;
    end else if (refill_last) begin
      rvalid_d = 1'b1;
      rdata_d  = (off_q == 2'd3) ? port_if.bus_rdata : rd_data;
    end
  end

  // Outputs: bus request during REFILL, array read port steering.
  always_comb begin
    port_if.bus_arvalid = (state_q == REFILL);
    port_if.bus_araddr  = '0;
    rd_idx              = pc_idx;
    rd_off              = pc_off;
    wr_valid            = !(fence_seen_q || fence_i);
    if (state_q == REFILL) begin
      port_if.bus_araddr = {base_q, beat_q, 2'b00};
      rd_idx             = base_idx;
      rd_off             = off_q;
    end
  end

  assign port_if.ifu_rvalid = rvalid_q;
  assign port_if.ifu_rdata  = rdata_q;
  assign dbg_state_o        = state_q;

`ifdef YSYX_ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Performance counters: IDLE hits and IDLE->REFILL transitions, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (idle_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (idle_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule
